// File: rtl/sfifo_pkt_reader.sv
// sfifo_pkt_reader: framing-aware drain stage for a show-ahead FIFO.
// Pops SOP/EOP-tagged words and presents them through a 2-entry output buffer.
// Along the way it drops orphan words, marks truncated and overlong packets,
// and counts terminated packets and framing errors.
module sfifo_pkt_reader #(
   parameter int WIDTH     = 64,
   parameter int LEN_NBITS = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [WIDTH+1:0]     fifo_dout,
   output logic                 fifo_rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic                 out_err,
   output logic [LEN_NBITS-1:0] out_len,
   output logic [31:0]          pkt_cnt,
   output logic [15:0]          err_cnt
);

   // One buffer entry packs {sop, eop, err, len, data}.
   localparam int ENT_W = WIDTH + LEN_NBITS + 3;
   localparam logic [LEN_NBITS-1:0] LEN_MAX = {LEN_NBITS{1'b1}};
   localparam logic [LEN_NBITS-1:0] LEN_ONE = {{(LEN_NBITS-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } state_t;

   state_t               state_r;
   logic [LEN_NBITS-1:0] len_r;
   logic [1:0]           obuf_cnt_r;
   logic [ENT_W-1:0]     slot0_r;
   logic [ENT_W-1:0]     slot1_r;
   logic [31:0]          pkt_cnt_r;
   logic [15:0]          err_cnt_r;

   logic                 word_sop_s;
   logic                 word_eop_s;
   logic [WIDTH-1:0]     word_data_s;
   logic                 rd_s;
   logic                 pop_s;
   logic                 push_s;
   logic                 pkt_inc_s;
   logic                 err_inc_s;
   logic                 ent_eop_s;
   logic                 ent_err_s;
   state_t               state_nxt_s;
   logic [LEN_NBITS-1:0] len_nxt_s;
   logic [LEN_NBITS-1:0] len_inc_s;
   logic [ENT_W-1:0]     ent_s;

   assign word_sop_s  = fifo_dout[WIDTH+1];
   assign word_eop_s  = fifo_dout[WIDTH];
   assign word_data_s = fifo_dout[WIDTH-1:0];

   // Read gating depends only on registered occupancy, never on out_ready.
   assign rd_s    = ~rst & ~fifo_empty & (obuf_cnt_r < 2'd2);
   assign fifo_rd = rd_s;
   assign pop_s   = (obuf_cnt_r != 2'd0) & out_ready;

   assign len_inc_s = len_r + LEN_ONE;
   assign ent_s     = {word_sop_s, ent_eop_s, ent_err_s, len_nxt_s, word_data_s};

   // Classify the popped head word against the framing state.
   always_comb begin
      push_s      = 1'b0;
      pkt_inc_s   = 1'b0;
      err_inc_s   = 1'b0;
      ent_eop_s   = word_eop_s;
      ent_err_s   = 1'b0;
      state_nxt_s = state_r;
      len_nxt_s   = len_r;
      if (rd_s) begin
         case (state_r)
            ST_IDLE: begin
               if (word_sop_s) begin
                  push_s    = 1'b1;
                  len_nxt_s = LEN_ONE;
                  if (word_eop_s) begin
                     pkt_inc_s   = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_IN_PKT;
                  end
               end else begin
                  // orphan: consumes the pop but not a buffer slot
                  err_inc_s = 1'b1;
               end
            end
            ST_IN_PKT: begin
               push_s = 1'b1;
               if (word_sop_s) begin
                  // truncation: the unfinished packet is abandoned
                  ent_err_s = 1'b1;
                  err_inc_s = 1'b1;
                  len_nxt_s = LEN_ONE;
                  if (word_eop_s) begin
                     pkt_inc_s   = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_IN_PKT;
                  end
               end else begin
                  len_nxt_s = len_inc_s;
                  if (word_eop_s) begin
                     pkt_inc_s   = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else if (len_inc_s == LEN_MAX) begin
                     // overlong: close the packet here, later words become orphans
                     ent_eop_s   = 1'b1;
                     ent_err_s   = 1'b1;
                     pkt_inc_s   = 1'b1;
                     err_inc_s   = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_IN_PKT;
                  end
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Framing state, running length and statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         len_r     <= {LEN_NBITS{1'b0}};
         pkt_cnt_r <= 32'd0;
         err_cnt_r <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         len_r   <= len_nxt_s;
         if (pkt_inc_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
         end
         if (err_inc_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end
      end
   end

   // Two-entry in-order output buffer; slot0 is always the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         obuf_cnt_r <= 2'd0;
         slot0_r    <= {ENT_W{1'b0}};
         slot1_r    <= {ENT_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (obuf_cnt_r == 2'd0) begin
                  slot0_r <= ent_s;
               end else begin
                  slot1_r <= ent_s;
               end
               obuf_cnt_r <= obuf_cnt_r + 2'd1;
            end
            2'b01: begin
               slot0_r    <= slot1_r;
               obuf_cnt_r <= obuf_cnt_r - 2'd1;
            end
            2'b11: begin
               // push implies occupancy below 2, so with a pop it must be 1
               slot0_r <= ent_s;
            end
            default: begin
               obuf_cnt_r <= obuf_cnt_r;
            end
         endcase
      end
   end

   assign out_valid = (obuf_cnt_r != 2'd0);
   assign out_data  = slot0_r[WIDTH-1:0];
   assign out_len   = slot0_r[WIDTH +: LEN_NBITS];
   assign out_err   = slot0_r[WIDTH+LEN_NBITS];
   assign out_eop   = slot0_r[WIDTH+LEN_NBITS+1];
   assign out_sop   = slot0_r[WIDTH+LEN_NBITS+2];
   assign pkt_cnt   = pkt_cnt_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_sfifo_pkt_reader.sv
// Bench for sfifo_pkt_reader: a wide-length instance (LEN_NBITS=12) and a
// short-length instance (LEN_NBITS=3) share one upstream FIFO model; sel picks
// which one is fed and observed. Expected words go into a scoreboard queue
// from a packet-rule model; a negedge monitor pops and compares.
module tb_sfifo_pkt_reader;
   localparam int W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         out_ready = 1'b1;
   logic         empty_a = 1'b1;
   logic         empty_b = 1'b1;
   logic [W+1:0] dout = '0;
   logic         rd_a, rd_b, valid_a, valid_b;
   logic [W-1:0] data_a, data_b;
   logic         sop_a, sop_b, eop_a, eop_b, err_a, err_b;
   logic [11:0]  len_a;
   logic [2:0]   len_b;
   logic [31:0]  pkt_a, pkt_b;
   logic [15:0]  errc_a, errc_b;

   sfifo_pkt_reader #(.WIDTH(W), .LEN_NBITS(12)) dut_a (
      .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_dout(dout), .fifo_rd(rd_a),
      .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a), .out_sop(sop_a),
      .out_eop(eop_a), .out_err(err_a), .out_len(len_a), .pkt_cnt(pkt_a), .err_cnt(errc_a));

   sfifo_pkt_reader #(.WIDTH(W), .LEN_NBITS(3)) dut_b (
      .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_dout(dout), .fifo_rd(rd_b),
      .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b), .out_sop(sop_b),
      .out_eop(eop_b), .out_err(err_b), .out_len(len_b), .pkt_cnt(pkt_b), .err_cnt(errc_b));

   logic         sel = 1'b0;
   logic         cur_valid, cur_sop, cur_eop, cur_err;
   logic [W-1:0] cur_data;
   logic [11:0]  cur_len;
   logic [31:0]  cur_pkt;
   logic [15:0]  cur_errc;

   always_comb begin
      if (sel) begin
         cur_valid = valid_b; cur_data = data_b; cur_sop = sop_b; cur_eop = eop_b;
         cur_err = err_b; cur_len = {9'd0, len_b}; cur_pkt = pkt_b; cur_errc = errc_b;
      end else begin
         cur_valid = valid_a; cur_data = data_a; cur_sop = sop_a; cur_eop = eop_a;
         cur_err = err_a; cur_len = len_a; cur_pkt = pkt_a; cur_errc = errc_a;
      end
   end

   typedef struct {
      logic [W-1:0] data;
      logic         sop;
      logic         eop;
      logic         err;
      int           len;
   } exp_t;

   exp_t         sb[$];
   logic [W+1:0] q_up[$];

   int n_cmp = 0, n_fail = 0;
   int cyc = 0, pop_cnt = 0, first_rd = -1, first_out = -1, last_out = -1;
   logic popped, up_empty;
   logic gaps = 1'b0, rand_ready = 1'b0, holding = 1'b0;
   logic [W-1:0] h_data;
   logic [14:0]  h_flags;
   exp_t mon_x;

   // reference model state: inside a packet?, its length, and the counters
   int m_in_pkt = 0, m_len = 0, m_pkt = 0, m_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic exp_push(input logic [W-1:0] d, input logic s, input logic e,
                           input logic er, input int l);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e; x.err = er; x.len = l;
      sb.push_back(x);
   endtask

   // Apply the packet framing rules to one word in upstream order.
   task automatic model_word(input logic s, input logic e, input logic [W-1:0] d);
      int maxl;
      maxl = sel ? 7 : 4095;
      if (m_in_pkt == 0) begin
         if (!s) begin
            m_err++;
         end else begin
            m_len = 1;
            exp_push(d, 1'b1, e, 1'b0, 1);
            if (e) m_pkt++;
            else m_in_pkt = 1;
         end
      end else if (s) begin
         m_err++;
         m_len = 1;
         exp_push(d, 1'b1, e, 1'b1, 1);
         if (e) begin m_pkt++; m_in_pkt = 0; end
      end else begin
         m_len++;
         if (e) begin
            exp_push(d, 1'b0, 1'b1, 1'b0, m_len);
            m_pkt++; m_in_pkt = 0;
         end else if (m_len == maxl) begin
            exp_push(d, 1'b0, 1'b1, 1'b1, m_len);
            m_pkt++; m_err++; m_in_pkt = 0;
         end else begin
            exp_push(d, 1'b0, 1'b0, 1'b0, m_len);
         end
      end
      if (m_err > 65535) m_err = 65535;
   endtask

   task automatic send(input logic s, input logic e, input logic [W-1:0] d);
      q_up.push_back({s, e, d});
      model_word(s, e, d);
   endtask

   task automatic model_clear();
      sb.delete();
      m_in_pkt = 0; m_len = 0; m_pkt = 0; m_err = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " out_valid"}, {63'd0, cur_valid}, 64'd0);
      check({tag, " out_data"}, cur_data, 64'd0);
      check({tag, " sop/eop/err/len"}, {49'd0, cur_sop, cur_eop, cur_err, cur_len}, 64'd0);
      check({tag, " pkt_cnt"}, {32'd0, cur_pkt}, 64'd0);
      check({tag, " err_cnt"}, {48'd0, cur_errc}, 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      q_up.delete();
      model_clear();
      @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (q_up.size() == 0 && sb.size() == 0 && !cur_valid) break;
      end
      if (k == 3000) begin
         n_cmp++; n_fail++;
         $display("FAIL drain timeout: %0d words still expected", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_cnt(input int p, input int e);
      check("pkt_cnt", {32'd0, cur_pkt}, p);
      check("err_cnt", {48'd0, cur_errc}, e);
   endtask

   // Upstream show-ahead FIFO: pop on the edge where fifo_rd was high.
   initial begin
      forever begin
         @(posedge clk);
         popped = sel ? rd_b : rd_a;
         if (popped) begin
            pop_cnt++;
            if (first_rd < 0) first_rd = cyc;
         end
         cyc++;
         #1;
         if (popped && q_up.size() != 0) void'(q_up.pop_front());
         up_empty = (q_up.size() == 0) || (gaps && ($urandom_range(0, 3) == 0));
         empty_a  = sel ? 1'b1 : up_empty;
         empty_b  = sel ? up_empty : 1'b1;
         dout     = (q_up.size() != 0) ? q_up[0] : '0;
      end
   end

   // Random downstream backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare each transferred word, and check stability while stalled.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && cur_valid) begin
            if (holding) begin
               check("stall data", cur_data, h_data);
               check("stall flags", {49'd0, cur_sop, cur_eop, cur_err, cur_len}, {49'd0, h_flags});
            end
            if (out_ready) begin
               holding = 1'b0;
               if (sb.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected word: got %0h, expected none", cur_data);
               end else begin
                  mon_x = sb.pop_front();
                  check("word data", cur_data, mon_x.data);
                  check("word sop/eop/err", {61'd0, cur_sop, cur_eop, cur_err},
                        {61'd0, mon_x.sop, mon_x.eop, mon_x.err});
                  if (mon_x.eop) check("word len", {52'd0, cur_len}, mon_x.len);
               end
               if (first_out < 0) first_out = cyc;
               last_out = cyc;
            end else begin
               holding = 1'b1;
               h_data  = cur_data;
               h_flags = {cur_sop, cur_eop, cur_err, cur_len};
            end
         end else begin
            holding = 1'b0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc;
      // single 4-word packet, latency and back-to-back delivery
      do_reset();
      first_rd = -1; first_out = -1;
      for (int i = 0; i < 4; i++) send(i == 0, i == 3, 64'(i + 1));
      drain();
      check("first word latency", first_out, first_rd + 1);
      check("consecutive delivery", last_out - first_out, 3);
      check_cnt(1, 0);

      // backpressure on an 8-word packet
      do_reset();
      out_ready = 1'b0;
      pc = pop_cnt;
      for (int i = 0; i < 8; i++) send(i == 0, i == 7, 64'h100 + 64'(i));
      repeat (5) @(posedge clk);
      #1;
      check("pops during stall", pop_cnt - pc, 2);
      check("stalled head", cur_data, 64'h100);
      out_ready = 1'b1;
      drain();
      check_cnt(1, 0);

      // orphans ahead of a single-word packet
      do_reset();
      send(1'b0, 1'b0, 64'hA1);
      send(1'b0, 1'b1, 64'hA2);
      send(1'b0, 1'b0, 64'hA3);
      send(1'b1, 1'b1, 64'hAB);
      drain();
      check_cnt(1, 3);

      // truncation by a new sop
      do_reset();
      send(1'b1, 1'b0, 64'hB1);
      send(1'b0, 1'b0, 64'hB2);
      send(1'b1, 1'b1, 64'hB3);
      drain();
      check_cnt(1, 1);

      // overlong packet on the LEN_NBITS=3 instance
      sel = 1'b1;
      do_reset();
      send(1'b1, 1'b0, 64'hC0);
      for (int i = 1; i < 9; i++) send(1'b0, 1'b0, 64'hC0 + 64'(i));
      drain();
      check_cnt(1, 3);
      sel = 1'b0;

      // reset in the middle of a 5-word packet with the buffer full
      do_reset();
      out_ready = 1'b0;
      pc = pop_cnt;
      for (int i = 0; i < 5; i++) q_up.push_back({i == 0, i == 4, 64'hD0 + 64'(i)});
      repeat (4) @(posedge clk);
      #1;
      check("pops before reset", pop_cnt - pc, 2);
      rst = 1'b1;
      @(negedge clk);
      check("fifo_rd in reset", {63'd0, rd_a}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check_zero("after mid-packet reset");
      for (int i = 2; i < 5; i++) model_word(1'b0, i == 4, 64'hD0 + 64'(i));
      out_ready = 1'b1;
      drain();
      check_cnt(0, 3);

      // randomized traffic on both instances
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_reset();
         gaps = 1'b1;
         rand_ready = 1'b1;
         for (int i = 0; i < 80; i++)
            send($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, {$urandom, $urandom});
         drain();
         rand_ready = 1'b0;
         gaps = 1'b0;
         #1;
         out_ready = 1'b1;
         check_cnt(m_pkt, m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sfifo_pkt_reader.md
# sfifo_pkt_reader

Framing-aware drain stage for a show-ahead FIFO (BRAM FIFO plus prefetch). Pops words tagged with SOP/EOP from the FIFO's read port and presents them to a downstream valid/ready consumer through a 2-entry registered output buffer. Checks packet framing on the way out:
- drops orphan words;
- flags truncated and overlong packets;
- keeps packet and error statistics.

## Interface
Parameters:
- WIDTH, 64, payload bits per word
- LEN_NBITS, 12, packet word-count width; max packet length is 2^LEN_NBITS-1 words

Ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  upstream FIFO empty
- fifo_dout  in  WIDTH+2  show-ahead head word: bit WIDTH+1 = sop, bit WIDTH = eop, [WIDTH-1:0] = payload
- fifo_rd  out  1  pop head word this cycle
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  payload
- out_sop  out  1  first word of packet
- out_eop  out  1  last word of packet
- out_err  out  1  framing error marker (see Operation)
- out_len  out  LEN_NBITS  packet length in words; meaningful when out_eop=1
- pkt_cnt  out  32  packets terminated (wraps)
- err_cnt  out  16  framing errors (saturates at 16'hFFFF)

## Operation
- **Read rule.** fifo_rd = ~fifo_empty & (obuf_cnt < 2).
  - obuf_cnt is the registered occupancy of the output buffer (0..2).
  - fifo_rd has no combinational path from out_ready.
- **Output buffer.** 2-entry FIFO, in-order.
  - Head drives out_*.
  - out_valid = (obuf_cnt != 0).
  - An entry pops on out_valid & out_ready.
  - Push and pop may occur in the same cycle.
- **Framing FSM** (evaluated on each popped word):
  - **IDLE, sop=0:** orphan.
    - Not pushed; err_cnt++.
    - Stays IDLE.
  - **IDLE, sop=1:** pushed with out_sop=1; len=1.
    - If eop=1: out_eop=1, out_len=1, pkt_cnt++, stay IDLE.
    - Else go to IN_PKT.
  - **IN_PKT, sop=0:** pushed; len++.
    - If eop=1: out_eop=1, out_len=len, pkt_cnt++, go to IDLE.
  - **IN_PKT, sop=1 (truncation):** pushed with out_sop=1 and out_err=1; err_cnt++.
    - The previous packet is not counted in pkt_cnt.
    - len restarts at 1; eop handling as in IDLE, sop=1.
  - **IN_PKT, len reaches 2^LEN_NBITS-1 on a word with eop=0 (overlong):** word pushed with forced out_eop=1 and out_err=1.
    - out_len = max; pkt_cnt++; err_cnt++; go to IDLE.
    - Following non-sop words are dropped as orphans, with err_cnt++ per word.
- **Output fields.** out_err=0 on all words not listed above.
- **Length counter.** len is LEN_NBITS wide and never wraps.
- **Counter updates.** Counters update in the cycle after the pop.
  - pkt_cnt wraps modulo 2^32.
  - err_cnt holds at 16'hFFFF.
- **Reset.**
  - FSM goes to IDLE.
  - obuf_cnt=0, len=0, pkt_cnt=0, err_cnt=0.
  - out_valid=0, out_data/out_sop/out_eop/out_err/out_len = 0.
  - fifo_rd=0 while rst=1.
  - Reset mid-packet discards buffered words. The next word must carry sop, else it is an orphan.

## Timing
- **Latency.** A word popped at cycle t (fifo_rd=1) appears on out_* at t+1 if the buffer is empty or its predecessors have drained.
- **Throughput.** 1 word/cycle sustained with out_ready=1: obuf_cnt holds at 1, with push and pop in the same cycle.
- **Backpressure.** With out_ready=0, at most 2 words are popped after out_ready falls, then fifo_rd=0.
  - When out_ready rises at cycle r, the head pops at r; fifo_rd reasserts at r+1.
- **Orphan drops.** Drops consume a FIFO pop but no buffer slot. They are still gated by obuf_cnt<2.
- **Handshake.** out_* are stable while out_valid=1 & out_ready=0.
- **Upstream.** fifo_dout is sampled only when fifo_rd=1; the upstream FIFO advances combinationally on fifo_rd.

## Test plan
- **Single 4-word packet, out_ready=1.**
  - Stimulus: sop on word0, eop on word3, payloads 1..4.
  - Required: out words 1..4 on consecutive cycles, first at one cycle after the first fifo_rd; out_len=4 on word 4; pkt_cnt=1; err_cnt=0.
- **Backpressure.**
  - Stimulus: 8-word packet queued; out_ready=0 for 5 cycles, then 1.
  - Required: exactly 2 pops during the stall; out_data held stable; all 8 words delivered in order; no duplicates.
- **Orphans.**
  - Stimulus: 3 non-sop words, then a 1-word sop+eop packet.
  - Required: only the packet word is output; err_cnt=3; pkt_cnt=1; out_len=1.
- **Truncation.**
  - Stimulus: sop, word, then sop+eop.
  - Required: 3 words output; third word has out_sop=1, out_err=1, out_eop=1; pkt_cnt=1; err_cnt=1.
- **Overlong packet (LEN_NBITS=3).**
  - Stimulus: sop + 9 words without eop.
  - Required: word 7 out with out_eop=1, out_err=1, out_len=7; words 8–9 dropped; err_cnt=3; pkt_cnt=1.
- **Reset mid-packet.**
  - Stimulus: rst pulsed for 1 cycle after 2 of 5 words with obuf_cnt=2.
  - Required: all outputs 0 the cycle after; remaining 3 non-sop words dropped; err_cnt=3 after reset.
